// File: rtl/ps2_pkg.sv
// Shared constants, types and the seven-segment table
// for the PS/2 scan-code capture and display block.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
  } scan_entry_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Active-low segments, bit0 = a .. bit6 = g
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser and 11-bit frame receiver with
// parity/stop checking and an inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q, dat_q;
  logic          fe_q;
  rx_state_e     state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] cnt_q;
  logic          valid_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      dat_q    <= 1'b1;
      fe_q     <= 1'b0;
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      // data is registered alongside fe so both refer to the same edge
      dat_q    <= dat_s2_q;
      fe_q     <= clk_s3_q & ~clk_s2_q;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      if (fe_q) begin
        cnt_q <= '0;
        unique case (state_q)
          RX_IDLE: begin
            if (!dat_q) begin
              state_q  <= RX_DATA;
              bitcnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q  <= {dat_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q   <= dat_q;
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_q && (^{shift_q, par_q})) valid_q <= 1'b1;
            else                              err_q   <= 1'b1;
            state_q <= RX_IDLE;
          end
        endcase
      end else if (state_q == RX_IDLE) begin
        cnt_q <= '0;
      end else if (cnt_q == TO_LAST) begin
        cnt_q   <= '0;
        state_q <= RX_IDLE;
        err_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = shift_q;
  assign rx_err_o   = err_q;

endmodule

// File: rtl/ps2_scan_history.sv
// PS/2 capture top: prefix decode, make-code history
// and active-low hex display of the stored codes.
module ps2_scan_history
  import ps2_pkg::*;
#(
  parameter int NUM_CODES      = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_BREAK   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ps2_clk,
  input  logic                               ps2_data,
  input  logic                               freeze,
  input  logic                               clear,
  output logic [2*NUM_CODES-1:0][6:0]        segments,
  output logic [7:0]                         last_code,
  output logic                               last_ext,
  output logic [$clog2(NUM_CODES+1)-1:0]     code_count,
  output logic                               new_code,
  output logic                               frame_err
);

  localparam int CW = $clog2(NUM_CODES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_CODES);
  localparam logic FILT = (FILTER_BREAK != 0);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .rx_valid_o(rx_valid),
    .rx_byte_o (rx_byte),
    .rx_err_o  (rx_err)
  );

  scan_entry_t [NUM_CODES-1:0] hist_q, hist_d;
  logic [CW-1:0] count_q, count_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          nc_q, push;

  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    hist_d  = hist_q;
    count_d = count_q;
    push    = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        (rx_byte == PS2_BREAK): brk_d = 1'b1;
        (rx_byte == PS2_EXT):   ext_d = 1'b1;
        default: begin
          push  = !(brk_q && FILT) && !freeze;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end
    if (push) begin
      for (int i = NUM_CODES - 1; i > 0; i--) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0].code = rx_byte;
      hist_d[0].ext  = ext_q;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end
    // clear overrides both a push and a prefix update
    if (clear) begin
      brk_d   = 1'b0;
      ext_d   = 1'b0;
      hist_d  = '0;
      count_d = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      count_q <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      nc_q    <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      nc_q    <= push;
    end
  end

  always_comb begin
    segments = {2*NUM_CODES{SEG_BLANK}};
    for (int i = 0; i < NUM_CODES; i++) begin
      if (CW'(i) < count_q) begin
        segments[2*i]   = hex7seg(hist_q[i].code[3:0]);
        segments[2*i+1] = hex7seg(hist_q[i].code[7:4]);
      end
    end
  end

  assign last_code  = hist_q[0].code;
  assign last_ext   = hist_q[0].ext;
  assign code_count = count_q;
  assign new_code   = nc_q;
  assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_scan_history.sv
// Directed bench for ps2_scan_history: frames, prefixes,
// errors, timeout, history depth, freeze and clear.
module tb_ps2_scan_history;

  localparam int NC = 3;
  localparam int TO = 200;

  logic            clk = 1'b0;
  logic            reset;
  logic            ps2_clk;
  logic            ps2_data;
  logic            freeze;
  logic            clear;
  logic [5:0][6:0] segments;
  logic [7:0]      last_code;
  logic            last_ext;
  logic [1:0]      code_count;
  logic            new_code;
  logic            frame_err;

  int errors = 0;
  int checks = 0;
  int nc_cnt = 0;
  int fe_cnt = 0;
  int nc_base;
  int fe_base;

  always #5 clk = ~clk;

  ps2_scan_history #(
    .NUM_CODES     (NC),
    .TIMEOUT_CYCLES(TO),
    .FILTER_BREAK  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .freeze    (freeze),
    .clear     (clear),
    .segments  (segments),
    .last_code (last_code),
    .last_ext  (last_ext),
    .code_count(code_count),
    .new_code  (new_code),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (new_code)  nc_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b1;
    wait_cyc(5);
  endtask

  // clr_stop holds clear high across the stop bit and the push slot
  task automatic send(input logic [7:0] b, input logic pflip,
                      input logic stop, input logic clr_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ pflip);
    if (clr_stop) clear = 1'b1;
    ps2_bit(stop);
    wait_cyc(20);
    clear = 1'b0;
    wait_cyc(10);
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    wait_cyc(2);
  endtask

  task automatic mark();
    nc_base = nc_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    freeze   = 1'b0;
    clear    = 1'b0;
    wait_cyc(5);
    chk("rst_cnt_low", 64'(code_count), 64'd0);
    reset = 1'b1;
    wait_cyc(5);

    chk("rst_seg",  64'(segments),   64'({6{7'h7F}}));
    chk("rst_cnt",  64'(code_count), 64'd0);
    chk("rst_last", 64'(last_code),  64'h00);
    chk("rst_nc",   64'(nc_cnt),     64'd0);
    chk("rst_err",  64'(fe_cnt),     64'd0);

    mark();
    good(8'h1C);
    chk("t2_nc",   64'(nc_cnt - nc_base), 64'd1);
    chk("t2_err",  64'(fe_cnt - fe_base), 64'd0);
    chk("t2_last", 64'(last_code),  64'h1C);
    chk("t2_ext",  64'(last_ext),   64'd0);
    chk("t2_cnt",  64'(code_count), 64'd1);
    chk("t2_seg",  64'(segments),
        64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h46}));

    pulse_clear();
    chk("clr_cnt", 64'(code_count), 64'd0);
    mark();
    good(8'h1C);
    good(8'hF0);
    good(8'h1C);
    chk("t3_nc",  64'(nc_cnt - nc_base), 64'd1);
    chk("t3_cnt", 64'(code_count), 64'd1);
    good(8'hE0);
    good(8'h75);
    chk("t3_last", 64'(last_code),  64'h75);
    chk("t3_ext",  64'(last_ext),   64'd1);
    chk("t3_cnt2", 64'(code_count), 64'd2);
    chk("t3_seg",  64'(segments),
        64'({7'h7F, 7'h7F, 7'h79, 7'h46, 7'h78, 7'h12}));

    mark();
    send(8'h1C, 1'b1, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t4_err",  64'(fe_cnt - fe_base), 64'd2);
    chk("t4_nc",   64'(nc_cnt - nc_base), 64'd0);
    chk("t4_last", 64'(last_code),  64'h75);
    chk("t4_cnt",  64'(code_count), 64'd2);

    mark();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    wait_cyc(TO + 50);
    chk("t5_err", 64'(fe_cnt - fe_base), 64'd1);
    chk("t5_nc",  64'(nc_cnt - nc_base), 64'd0);
    good(8'h24);
    chk("t5_last", 64'(last_code),  64'h24);
    chk("t5_ext",  64'(last_ext),   64'd0);
    chk("t5_cnt",  64'(code_count), 64'd3);
    chk("t5_err2", 64'(fe_cnt - fe_base), 64'd1);

    pulse_clear();
    good(8'h11);
    good(8'h22);
    good(8'h33);
    good(8'h44);
    chk("t6_last", 64'(last_code),  64'h44);
    chk("t6_cnt",  64'(code_count), 64'd3);
    chk("t6_seg",  64'(segments),
        64'({7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19}));

    mark();
    freeze = 1'b1;
    good(8'h55);
    freeze = 1'b0;
    chk("t6_frz_nc",   64'(nc_cnt - nc_base), 64'd0);
    chk("t6_frz_last", 64'(last_code), 64'h44);
    chk("t6_frz_cnt",  64'(code_count), 64'd3);

    mark();
    send(8'h66, 1'b0, 1'b1, 1'b1);
    chk("t6_clr_nc",   64'(nc_cnt - nc_base), 64'd0);
    chk("t6_clr_cnt",  64'(code_count), 64'd0);
    chk("t6_clr_last", 64'(last_code),  64'h00);
    chk("t6_clr_seg",  64'(segments),   64'({6{7'h7F}}));

    mark();
    good(8'h24);
    chk("t6_after_nc",   64'(nc_cnt - nc_base), 64'd1);
    chk("t6_after_last", 64'(last_code), 64'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_history.md
Name: ps2_scan_history

Overview:
- Parametrised next-generation keyboard capture block: samples raw PS/2 clock/data in the system clock domain and checks each 11-bit frame (start, parity, stop, timeout).
- Handles E0/F0 prefixes and keeps a history of the last NUM_CODES make codes.
- Drives 2*NUM_CODES active-low seven-segment digits, two hex digits per code.
- Sits between the board PS/2 pins and the HEX displays as a single self-contained capture/display block.

Parameters:
- NUM_CODES, 3, history depth; drives 2*NUM_CODES digits (min 1).
- TIMEOUT_CYCLES, 50000, idle clk cycles after which a partial frame is aborted (1 ms at 50 MHz).
- FILTER_BREAK, 1, 1: discard the code following F0; 0: push it as well.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- freeze  in  1  1: history does not accept pushes
- clear  in  1  synchronous history clear
- segments  out  [2*NUM_CODES-1:0][6:0]  active-low digits, bit0=a..bit6=g
- last_code  out  8  newest history entry
- last_ext  out  1  newest entry was E0-prefixed
- code_count  out  $clog2(NUM_CODES+1)  valid entries, saturating
- new_code  out  1  one-cycle pulse on each push
- frame_err  out  1  one-cycle pulse on parity/stop/timeout error

Behaviour:
- Reset (reset=0, async): all history entries and ext flags 0; code_count 0; prefix flags 0; receiver FSM IDLE; new_code=0, frame_err=0; segments all 7'h7F (blank).
- Input sync: 2-FF synchronizer on each pin. The falling-edge strobe fe is registered, asserting the cycle after the synced clock goes 1->0. This strobe cycle is E.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. All transitions happen on fe.
  - IDLE: fe with data=0 -> DATA with bitcnt=0. fe with data=1 is ignored.
  - DATA: shift LSB first. After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: frame good iff data=1 and odd parity over data+parity. Good: rx_valid pulses at E+1. Bad: frame_err pulses at E+1, byte discarded. Either way -> IDLE.
  - Timeout counter: zeroed on every fe and while IDLE. Reaching TIMEOUT_CYCLES in a non-IDLE state -> IDLE plus a frame_err pulse next cycle.
- Decode, on rx_valid:
  - 0xF0: set brk. No push.
  - 0xE0: set ext. No push.
  - Any other code: if brk and FILTER_BREAK, discard. Otherwise push {code, ext}. Clear brk and ext in both cases.
  - Prefix flags update even when freeze=1.
- History: entry 0 is newest. A push shifts entry i to i+1 and drops the oldest; code_count saturates at NUM_CODES. Push registers at E+2, and new_code pulses in that same cycle.
- freeze=1: push dropped, no new_code pulse.
- clear=1: entries, ext flags, count and prefix flags all zeroed. clear beats a simultaneous push (result count 0, no new_code pulse). clear beats freeze.
- Display: combinational from history registers, no added latency.
  - Digit 2i = low nibble of entry i; digit 2i+1 = high nibble.
  - Digits for i >= code_count show 7'h7F (blank).
  - Hex encoding table is fixed in the package (e.g. 0=7'h40, 1=7'h79, C=7'h46).
- last_code/last_ext = entry 0 (0/0 when empty).
- Reset mid-frame: FSM to IDLE immediately. The next valid start bit is received normally.

Decomposition:
- Package ps2_pkg:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, SEG_BLANK=7'h7F
  - 16-entry hex-to-seven-segment table/function
  - typedef scan_entry_t {code[7:0], ext}
- Sub-module ps2_frame_rx: synchronizer, edge detect, FSM, timeout. Outputs rx_valid, rx_byte, rx_err.
- Top level holds prefix decode, history shift register and display mapping.

Test Plan:
1. Reset low then high, idle pins -> segments all 7'h7F, code_count=0, last_code=8'h00, no pulses.
2. Frame 0x1C (parity bit 0, stop 1) -> rx at E+1, new_code at E+2, last_code=8'h1C, code_count=1, segments[1]=7'h79, segments[0]=7'h46, others 7'h7F.
3. Frames 1C, F0, 1C with FILTER_BREAK=1 -> one new_code pulse, code_count=1. Then E0, 75 -> last_code=8'h75, last_ext=1, code_count=2.
4. Frame 0x1C with wrong parity bit, then a frame with stop=0 -> two frame_err pulses, history unchanged.
5. Five falling edges then silence for TIMEOUT_CYCLES -> one frame_err pulse, FSM IDLE. Next good frame 0x24 -> last_code=8'h24.
6. NUM_CODES=3, push 11,22,33,44 -> entries 44,33,22, count 3. freeze=1 then push 55 -> unchanged, no new_code. clear asserted in the same cycle as a push -> count 0, all digits blank.
